// File: rtl/serial_alu_arbiter.sv
// serial_alu_arbiter: round-robin arbiter for two requesters sharing one bit-serial ALU
module serial_alu_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic             owner,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             sign
);
    localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, nxt;
    logic [IW-1:0] idx;
    logic [1:0] op;
    logic [WIDTH-1:0] ra, rb, acc, nacc;
    logic c, cn, s, ab, bb, prio, pick, take, last;
    // prio high means requester 1 wins a tie
    always_comb begin
        take = req0 | req1;
        pick = req1 & (~req0 | prio);
        ab = ra[idx];
        bb = rb[idx];
        last = idx == IW'(WIDTH - 1);
        s = op == 2'b11 ? ab & bb : op == 2'b10 ? ab ^ bb : ab ^ bb ^ c;
        cn = op == 2'b00 ? (ab & bb) | (ab & c) | (bb & c) :
             op == 2'b01 ? (~ab & bb) | (~ab & c) | (bb & c) : 1'b0;
        nacc = acc;
        nacc[idx] = s;
        nxt = state == IDLE ? (take ? BUSY : IDLE) : state == BUSY ? (last ? DONE : BUSY) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            op <= '0;
            ra <= '0;
            rb <= '0;
            acc <= '0;
            c <= 1'b0;
            prio <= 1'b0;
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            busy <= 1'b0;
            owner <= 1'b0;
            result <= '0;
            zero <= 1'b0;
            carry <= 1'b0;
            sign <= 1'b0;
        end else begin
            state <= nxt;
            busy <= nxt != IDLE;
            gnt0 <= state == IDLE && take && !pick;
            gnt1 <= state == IDLE && take && pick;
            done0 <= state == DONE && !owner;
            done1 <= state == DONE && owner;
            if (state == IDLE && take) begin
                owner <= pick;
                prio <= ~pick;
                op <= pick ? op1 : op0;
                ra <= pick ? a1 : a0;
                rb <= pick ? b1 : b0;
                idx <= '0;
                c <= 1'b0;
                acc <= '0;
            end
            if (state == BUSY) begin
                acc <= nacc;
                c <= cn;
                idx <= idx + 1'b1;
                if (last) begin
                    result <= nacc;
                    zero <= ~|nacc;
                    sign <= nacc[WIDTH-1];
                    carry <= cn;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_alu_arbiter.sv
// tb_serial_alu_arbiter: cycle-level model built from operation timeline and whole-word arithmetic
module tb_serial_alu_arbiter;
    localparam int W = 4;
    logic clk = 1'b0;
    logic reset, req0, req1;
    logic [1:0] op0, op1;
    logic [W-1:0] a0, b0, a1, b1, result;
    logic gnt0, gnt1, done0, done1, busy, owner, zero, carry, sign;
    int checks = 0;
    int failures = 0;
    logic started = 1'b0;
    always #5 clk = ~clk;
    serial_alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1), .busy(busy), .owner(owner),
        .result(result), .zero(zero), .carry(carry), .sign(sign)
    );
    task automatic check(input string n, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
        end
    endtask
    function automatic logic [W:0] alu(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        case (o)
            2'd0: return {1'b0, a} + {1'b0, b};
            2'd1: return {1'b0, a} - {1'b0, b};
            2'd2: return {1'b0, a ^ b};
            default: return {1'b0, a & b};
        endcase
    endfunction
    // k counts edges since the accepting edge; 0 or W+2 means the arbiter can accept
    int k = 0;
    logic m_owner = 1'b0, m_last = 1'b1, m_c = 1'b0, m_z = 1'b0;
    logic [1:0] m_op = '0;
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic [W:0] f;
    logic pk;
    always_comb begin
        pk = (req0 && req1) ? ~m_last : req1;
        f = alu(m_op, m_a, m_b);
    end
    always @(posedge clk) begin
        if (reset) begin
            k <= 0;
            m_owner <= 1'b0;
            m_last <= 1'b1;
            m_res <= '0;
            m_c <= 1'b0;
            m_z <= 1'b0;
        end else if (k == 0 || k == W + 2) begin
            if (req0 || req1) begin
                k <= 1;
                m_owner <= pk;
                m_last <= pk;
                m_op <= pk ? op1 : op0;
                m_a <= pk ? a1 : a0;
                m_b <= pk ? b1 : b0;
            end else k <= 0;
        end else begin
            k <= k + 1;
            if (k == W) begin
                m_res <= f[W-1:0];
                m_c <= f[W];
                m_z <= f[W-1:0] == '0;
            end
        end
    end
    always @(negedge clk) begin
        if (started) begin
            check("gnt0", gnt0, k == 1 && !m_owner);
            check("gnt1", gnt1, k == 1 && m_owner);
            check("done0", done0, k == W + 2 && !m_owner);
            check("done1", done1, k == W + 2 && m_owner);
            check("busy", busy, k >= 1 && k <= W + 1);
            check("owner", owner, m_owner);
            check("result", result, m_res);
            check("zero", zero, m_z);
            check("carry", carry, m_c);
            check("sign", sign, m_res[W-1]);
        end
    end
    task automatic run(input logic r, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] nb, output int ng, output int nd);
        @(negedge clk);
        if (r) begin req1 = 1; op1 = op; a1 = a; b1 = b; end
        else begin req0 = 1; op0 = op; a0 = a; b0 = b; end
        ng = 0;
        do begin @(negedge clk); ng++; end while (!(gnt0 | gnt1) && ng < 20);
        req0 = 0;
        req1 = 0;
        if (r) b1 = nb; else b0 = nb;
        nd = 0;
        while (!(done0 | done1) && nd < 20) begin @(negedge clk); nd++; end
    endtask
    int ng, nd, cnt;
    logic [1:0] ord [4];
    initial begin
        reset = 1; req0 = 0; req1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        repeat (2) @(negedge clk);
        started = 1;
        reset = 0;
        check("rst_busy", busy, 0);
        check("rst_zero", zero, 0);
        run(0, 2'b00, 4'd7, 4'd9, 4'd9, ng, nd);
        check("add_gnt_lat", ng, 1);
        check("add_done_lat", nd, 5);
        check("add_done0", done0, 1);
        check("add_res", result, 4'h0);
        check("add_flags", {zero, carry, sign}, 3'b110);
        run(1, 2'b01, 4'd3, 4'd5, 4'd5, ng, nd);
        check("sub_done1", {done1, done0}, 2'b10);
        check("sub_res", result, 4'hE);
        check("sub_flags", {zero, carry, sign}, 3'b011);
        run(0, 2'b10, 4'hA, 4'hA, 4'hA, ng, nd);
        check("xor_res", result, 4'h0);
        check("xor_flags", {zero, carry}, 2'b10);
        run(1, 2'b11, 4'hC, 4'hA, 4'hA, ng, nd);
        check("and_res", result, 4'h8);
        check("and_sign", sign, 1);
        run(0, 2'b00, 4'd3, 4'd4, 4'hF, ng, nd);
        check("hold_res", result, 4'h7);
        @(negedge clk);
        req0 = 1; op0 = 2'b00; a0 = 4'd5; b0 = 4'd6;
        @(negedge clk);
        req0 = 0;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_res", result, 0);
        check("mid_rst_flags", {zero, carry, sign, owner}, 4'b0000);
        run(0, 2'b00, 4'd5, 4'd6, 4'd6, ng, nd);
        check("post_rst_lat", nd, 5);
        check("post_rst_res", result, 4'hB);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 4; i++) ord[i] = 2'd3;
        req0 = 1; req1 = 1; op0 = 2'b00; op1 = 2'b10;
        a0 = 4'd1; b0 = 4'd2; a1 = 4'h5; b1 = 4'hF;
        cnt = 0;
        for (int i = 0; i < 40 && cnt < 4; i++) begin
            @(negedge clk);
            if (gnt0 | gnt1) begin
                ord[cnt] = {1'b0, gnt1};
                cnt++;
            end
        end
        req0 = 0;
        req1 = 0;
        check("arb_0", ord[0], 0);
        check("arb_1", ord[1], 1);
        check("arb_2", ord[2], 0);
        check("arb_3", ord[3], 1);
        repeat (10) @(negedge clk);
        check("arb_end_res", result, 4'hA);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
